// File: rtl/alpha_finder_iterative.sv
// Alpha finder, multicycle version.
// Joins one numerator and one denominator beat, then produces
// alpha = clamp(floor(N*2^F/D) or round-half-up, 0, 2^W-1) using a restoring
// divider that retires one quotient bit per cycle.
module alpha_finder_iterative #(
  parameter int DATA_WIDTH     = 16,
  parameter int BLOCK_SIZE_LOG = 8,
  parameter int ALPHA_WIDTH    = 10,
  parameter int ALPHA_FRAC     = 9,
  parameter int ROUNDING       = 0
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [2*DATA_WIDTH+2+BLOCK_SIZE_LOG-1:0]     alphan_data,
  input  logic                                         alphan_valid,
  output logic                                         alphan_ready,
  input  logic [2*DATA_WIDTH+2+BLOCK_SIZE_LOG-1:0]     alphad_data,
  input  logic                                         alphad_valid,
  output logic                                         alphad_ready,
  output logic [ALPHA_WIDTH-1:0]                       output_data,
  output logic                                         output_sat,
  output logic                                         output_dz,
  output logic                                         output_valid,
  input  logic                                         output_ready
);

  localparam int IN_WIDTH = 2*DATA_WIDTH + 2 + BLOCK_SIZE_LOG;
  localparam int RW       = IN_WIDTH + 1;                           // remainder / divisor width
  localparam int XW       = IN_WIDTH + ALPHA_FRAC;                  // scaled dividend width
  localparam int SW       = IN_WIDTH + ALPHA_WIDTH - ALPHA_FRAC + 1; // saturation compare width
  localparam int CW       = $clog2(ALPHA_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    DIV   = 3'd2,
    ROUND = 3'd3,
    OUT   = 3'd4
  } state_t;

  state_t                 state;
  logic [IN_WIDTH-1:0]    n_reg;
  logic [IN_WIDTH-1:0]    d_reg;
  logic [RW-1:0]          rem;
  logic [RW-1:0]          d_mag;
  logic [ALPHA_WIDTH-1:0] xlow;
  logic [ALPHA_WIDTH-1:0] quot;
  logic [CW-1:0]          cnt;
  logic [ALPHA_WIDTH-1:0] res;
  logic                   res_sat;
  logic                   res_dz;

  logic                   accept;
  logic                   d_nonpos;
  logic                   n_nonpos;
  logic                   sat_hit;
  logic [XW-1:0]          x_full;
  logic [RW-1:0]          trial;
  logic                   trial_ge;
  logic [RW-1:0]          step_rem;
  logic                   round_up;

  // Both beats are taken on the same edge, only from IDLE and never during reset.
  assign accept       = (state == IDLE) & alphan_valid & alphad_valid & rst;
  assign alphan_ready = accept;
  assign alphad_ready = accept;

  // Sign checks, early saturation test and one restoring division step.
  always_comb begin
    d_nonpos = d_reg[IN_WIDTH-1] | (d_reg == {IN_WIDTH{1'b0}});
    n_nonpos = n_reg[IN_WIDTH-1] | (n_reg == {IN_WIDTH{1'b0}});
    // N >= D<<(W-F) means the quotient cannot fit in W bits.
    sat_hit  = SW'(n_reg) >= (SW'(d_reg) << (ALPHA_WIDTH - ALPHA_FRAC));
    x_full   = XW'(n_reg) << ALPHA_FRAC;
    // R < D < 2^(IN_WIDTH-1), so dropping the remainder MSB before the shift loses nothing.
    trial    = {rem[IN_WIDTH-1:0], xlow[ALPHA_WIDTH-1]};
    trial_ge = trial >= d_mag;
    if (trial_ge) begin
      step_rem = trial - d_mag;
    end else begin
      step_rem = trial;
    end
    round_up = {rem, 1'b0} >= {1'b0, d_mag};
  end

  // Control FSM with datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      n_reg        <= {IN_WIDTH{1'b0}};
      d_reg        <= {IN_WIDTH{1'b0}};
      rem          <= {RW{1'b0}};
      d_mag        <= {RW{1'b0}};
      xlow         <= {ALPHA_WIDTH{1'b0}};
      quot         <= {ALPHA_WIDTH{1'b0}};
      cnt          <= {CW{1'b0}};
      res          <= {ALPHA_WIDTH{1'b0}};
      res_sat      <= 1'b0;
      res_dz       <= 1'b0;
      output_data  <= {ALPHA_WIDTH{1'b0}};
      output_sat   <= 1'b0;
      output_dz    <= 1'b0;
      output_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            n_reg <= alphan_data;
            d_reg <= alphad_data;
            state <= CHECK;
          end else begin
            state <= IDLE;
          end
        end
        CHECK: begin
          d_mag   <= {1'b0, d_reg};
          rem     <= RW'(x_full >> ALPHA_WIDTH);
          xlow    <= x_full[ALPHA_WIDTH-1:0];
          quot    <= {ALPHA_WIDTH{1'b0}};
          cnt     <= {CW{1'b0}};
          res     <= {ALPHA_WIDTH{1'b0}};
          res_sat <= 1'b0;
          res_dz  <= 1'b0;
          if (d_nonpos) begin
            res_dz <= 1'b1;
            state  <= OUT;
          end else if (n_nonpos) begin
            state  <= OUT;
          end else if (sat_hit) begin
            res     <= {ALPHA_WIDTH{1'b1}};
            res_sat <= 1'b1;
            state   <= OUT;
          end else begin
            state <= DIV;
          end
        end
        DIV: begin
          rem  <= step_rem;
          xlow <= xlow << 1;
          quot <= (quot << 1) | ALPHA_WIDTH'(trial_ge);
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(ALPHA_WIDTH - 1)) begin
            res <= (quot << 1) | ALPHA_WIDTH'(trial_ge);
            if (ROUNDING != 0) begin
              state <= ROUND;
            end else begin
              state <= OUT;
            end
          end else begin
            state <= DIV;
          end
        end
        ROUND: begin
          if (round_up && (&quot)) begin
            res     <= {ALPHA_WIDTH{1'b1}};
            res_sat <= 1'b1;
          end else if (round_up) begin
            res <= quot + ALPHA_WIDTH'(1);
          end else begin
            res <= quot;
          end
          state <= OUT;
        end
        OUT: begin
          if (!output_valid) begin
            output_data  <= res;
            output_sat   <= res_sat;
            output_dz    <= res_dz;
            output_valid <= 1'b1;
          end else if (output_ready) begin
            output_data  <= {ALPHA_WIDTH{1'b0}};
            output_sat   <= 1'b0;
            output_dz    <= 1'b0;
            output_valid <= 1'b0;
            state        <= IDLE;
          end else begin
            state <= OUT;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
